if_fetch_unit: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the fetch/decode stage.
- Generates the fetch PC and drives the instruction-memory request/response handshake.
- Buffers returned words in a small prefetch FIFO of {pc, instruction} pairs.
- Presents a valid/stall interface to decode and handles redirect flushes and misaligned-target exceptions.

---
 rtl/if_fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Fetch front end - PC generation, one-outstanding imem request,
//               {pc, instr} prefetch FIFO, redirect flush, misalign trap.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
    parameter logic [31:0] RESET      = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP        = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_mem_ren,
    output logic [31:0] inst_mem_address,
    input  logic        inst_mem_is_valid,
    input  logic [31:0] inst_mem_read_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    output logic        misalign_exception,
    output logic [2:0]  fifo_count
);

    localparam int         PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [3:0] c_DEPTH = 4'(FIFO_DEPTH);

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      req_pc_q;
    logic             misalign_q;
    logic [2:0]       count_q, count_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;

    logic [31:0]      fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]      fifo_inst_q [FIFO_DEPTH];

    logic             push;
    logic             pop;
    logic             room;
    logic             ren;
    logic             not_empty;
    logic [3:0]       occ_next;

    assign not_empty = (count_q != 3'd0);
    assign push      = (state_q == S_WAIT) & inst_mem_is_valid & ~redirect;
    assign pop       = if_valid & ~stall;
    assign occ_next  = {1'b0, count_q} + {3'b000, push} - {3'b000, pop};
    assign room      = (occ_next < c_DEPTH);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (ren) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    state_d = inst_mem_is_valid ? S_RUN : S_DROP;
                end else if (inst_mem_is_valid) begin
                    state_d = ren ? S_WAIT : S_RUN;
                end
            end
            S_DROP: begin
                if (inst_mem_is_valid) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // Output logic: issue on the response cycle keeps one request per cycle
    always_comb begin
        ren = reset & ~redirect & ~misalign_q & room &
              ((state_q == S_RUN) | ((state_q == S_WAIT) & inst_mem_is_valid));
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = occ_next[2:0];
        head_d     = head_q;
        tail_d     = tail_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            count_d    = 3'd0;
            head_d     = '0;
            tail_d     = '0;
        end else begin
            if (ren) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET;
            req_pc_q   <= RESET;
            misalign_q <= 1'b0;
            count_q    <= 3'd0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            if (ren) begin
                req_pc_q <= fetch_pc_q;
            end
            if (redirect && (redirect_pc[1:0] != 2'b00)) begin
                misalign_q <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset; count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[tail_q]   <= req_pc_q;
            fifo_inst_q[tail_q] <= inst_mem_read_data;
        end
    end

    assign inst_mem_ren       = ren;
    assign inst_mem_address   = fetch_pc_q;
    assign if_valid           = not_empty & ~redirect;
    assign if_instruction     = if_valid ? fifo_inst_q[head_q] : NOP;
    assign if_pc              = not_empty ? fifo_pc_q[head_q] : 32'h0000_0000;
    assign misalign_exception = misalign_q;
    assign fifo_count         = count_q;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Directed bench for if_fetch_unit with a variable-latency imem.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        inst_mem_ren;
    logic [31:0] inst_mem_address;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_data = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic        misalign_exception;
    logic [2:0]  fifo_count;

    int n_checks = 0;
    int n_errors = 0;
    int mem_lat  = 1;

    if_fetch_unit #(
        .RESET      (32'h0000_0000),
        .FIFO_DEPTH (2),
        .NOP        (c_NOP)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .inst_mem_ren       (inst_mem_ren),
        .inst_mem_address   (inst_mem_address),
        .inst_mem_is_valid  (mem_valid),
        .inst_mem_read_data (mem_data),
        .redirect           (redirect),
        .redirect_pc        (redirect_pc),
        .stall              (stall),
        .if_valid           (if_valid),
        .if_instruction     (if_instruction),
        .if_pc              (if_pc),
        .misalign_exception (misalign_exception),
        .fifo_count         (fifo_count)
    );

    always #5 clk = ~clk;

    // Memory model: request seen late in the cycle, answered mem_lat edges later
    always begin : mem_model
        logic        s_ren;
        logic        s_rst;
        logic [31:0] s_addr;
        int          cnt;
        logic [31:0] addr;
        cnt  = 0;
        addr = 32'h0;
        forever begin
            @(negedge clk);
            #4;
            s_ren  = inst_mem_ren;
            s_addr = inst_mem_address;
            s_rst  = reset;
            @(posedge clk);
            #1;
            mem_valid = 1'b0;
            if (!s_rst) begin
                cnt = 0;
            end else begin
                if (s_ren) begin
                    cnt  = mem_lat;
                    addr = s_addr;
                end
                if (cnt > 0) begin
                    cnt = cnt - 1;
                    if (cnt == 0) begin
                        mem_valid = 1'b1;
                        mem_data  = addr | 32'h1300_0000;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset(input int lat);
        @(negedge clk);
        reset       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        mem_lat     = lat;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic wait_valid(input int budget, input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (if_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk(tag, {31'b0, got}, 32'd1);
    endtask

    initial begin : stim
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ren",    {31'b0, inst_mem_ren},       32'd0);
        chk("rst_addr",   inst_mem_address,            32'h0);
        chk("rst_valid",  {31'b0, if_valid},           32'd0);
        chk("rst_inst",   if_instruction,              c_NOP);
        chk("rst_pc",     if_pc,                       32'h0);
        chk("rst_count",  {29'b0, fifo_count},         32'd0);
        chk("rst_misal",  {31'b0, misalign_exception}, 32'd0);

        // Streaming at 1-cycle latency
        reset = 1'b1;
        #1;
        chk("s_c0_ren",  {31'b0, inst_mem_ren}, 32'd1);
        chk("s_c0_addr", inst_mem_address,      32'h0);
        tick();
        chk("s_c1_ren",   {31'b0, inst_mem_ren}, 32'd1);
        chk("s_c1_addr",  inst_mem_address,      32'h4);
        chk("s_c1_valid", {31'b0, if_valid},     32'd0);
        tick();
        chk("s_c2_valid", {31'b0, if_valid},     32'd1);
        chk("s_c2_pc",    if_pc,                 32'h0);
        chk("s_c2_inst",  if_instruction,        32'h1300_0000);
        chk("s_c2_count", {29'b0, fifo_count},   32'd1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("s_pc",    if_pc,                 32'(4 * k));
            chk("s_inst",  if_instruction,        32'h1300_0000 | 32'(4 * k));
            chk("s_count", {29'b0, fifo_count},   32'd1);
        end

        // Stall fills the FIFO, then drains in order
        do_reset(1);
        tick();
        tick();
        chk("st_pc0", if_pc, 32'h0);
        stall = 1'b1;
        #1;
        chk("st_ren_now", {31'b0, inst_mem_ren}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("st_count", {29'b0, fifo_count},   32'd2);
            chk("st_ren",   {31'b0, inst_mem_ren}, 32'd0);
            chk("st_pc",    if_pc,                 32'h0);
            chk("st_valid", {31'b0, if_valid},     32'd1);
        end
        stall = 1'b0;
        #1;
        chk("st_rel_ren",  {31'b0, inst_mem_ren}, 32'd1);
        chk("st_rel_addr", inst_mem_address,      32'h8);
        tick();
        chk("st_d1_pc",    if_pc,               32'h4);
        chk("st_d1_count", {29'b0, fifo_count}, 32'd1);
        tick();
        chk("st_d2_pc", if_pc, 32'h8);
        tick();
        chk("st_d3_pc", if_pc, 32'hC);

        // Redirect while a 3-cycle request is in flight
        do_reset(3);
        chk("d_c0_addr", inst_mem_address, 32'h0);
        tick();
        chk("d_c1_ren", {31'b0, inst_mem_ren}, 32'd0);
        tick();
        tick();
        chk("d_c3_ren",  {31'b0, inst_mem_ren}, 32'd1);
        chk("d_c3_addr", inst_mem_address,      32'h4);
        tick();
        chk("d_c4_pc",  if_pc,                 32'h0);
        chk("d_c4_ren", {31'b0, inst_mem_ren}, 32'd0);
        tick();
        chk("d_c5_count", {29'b0, fifo_count}, 32'd0);
        tick();
        chk("d_c6_addr", inst_mem_address, 32'h8);
        tick();
        chk("d_c7_pc", if_pc, 32'h4);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        #1;
        chk("d_rd_valid", {31'b0, if_valid},     32'd0);
        chk("d_rd_ren",   {31'b0, inst_mem_ren}, 32'd0);
        @(posedge clk);
        #1;
        redirect = 1'b0;
        tick();
        chk("d_c8_count", {29'b0, fifo_count},   32'd0);
        chk("d_c8_ren",   {31'b0, inst_mem_ren}, 32'd0);
        chk("d_c8_addr",  inst_mem_address,      32'h100);
        tick();
        chk("d_c9_ren",   {31'b0, inst_mem_ren}, 32'd0);
        chk("d_c9_valid", {31'b0, if_valid},     32'd0);
        tick();
        chk("d_c10_ren",  {31'b0, inst_mem_ren}, 32'd1);
        chk("d_c10_addr", inst_mem_address,      32'h100);
        wait_valid(10, "d_wait_valid");
        chk("d_first_pc",   if_pc,          32'h100);
        chk("d_first_inst", if_instruction, 32'h1300_0100);

        // Redirect coinciding with a response while the FIFO holds an entry
        do_reset(1);
        tick();
        tick();
        chk("r_c2_count", {29'b0, fifo_count}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        #1;
        chk("r_valid", {31'b0, if_valid},     32'd0);
        chk("r_inst",  if_instruction,        c_NOP);
        chk("r_ren",   {31'b0, inst_mem_ren}, 32'd0);
        @(posedge clk);
        #1;
        redirect = 1'b0;
        tick();
        chk("r_c3_count", {29'b0, fifo_count},   32'd0);
        chk("r_c3_valid", {31'b0, if_valid},     32'd0);
        chk("r_c3_ren",   {31'b0, inst_mem_ren}, 32'd1);
        chk("r_c3_addr",  inst_mem_address,      32'h40);
        tick();
        chk("r_c4_count", {29'b0, fifo_count}, 32'd0);
        chk("r_c4_addr",  inst_mem_address,    32'h44);
        tick();
        chk("r_c5_pc",   if_pc,          32'h40);
        chk("r_c5_inst", if_instruction, 32'h1300_0040);

        // PC wrap at the top of the address space
        do_reset(1);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        tick();
        chk("w_addr_top", inst_mem_address, 32'hFFFF_FFFC);
        tick();
        chk("w_addr_wrap", inst_mem_address,     32'h0);
        chk("w_ren_wrap",  {31'b0, inst_mem_ren}, 32'd1);
        tick();
        chk("w_pc", if_pc, 32'hFFFF_FFFC);

        // Misaligned redirect is sticky until reset
        do_reset(1);
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        tick();
        chk("m_flag",  {31'b0, misalign_exception}, 32'd1);
        chk("m_addr",  inst_mem_address,            32'h102);
        chk("m_count", {29'b0, fifo_count},         32'd0);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("m_ren",    {31'b0, inst_mem_ren},       32'd0);
            chk("m_valid",  {31'b0, if_valid},           32'd0);
            chk("m_sticky", {31'b0, misalign_exception}, 32'd1);
        end
        reset = 1'b0;
        #1;
        chk("m_rst_flag", {31'b0, misalign_exception}, 32'd0);
        chk("m_rst_ren",  {31'b0, inst_mem_ren},       32'd0);
        tick();
        reset = 1'b1;
        #1;
        chk("m_rel_ren",  {31'b0, inst_mem_ren}, 32'd1);
        chk("m_rel_addr", inst_mem_address,      32'h0);

        // Asynchronous reset with a full FIFO
        do_reset(1);
        tick();
        tick();
        stall = 1'b1;
        tick();
        chk("f_full", {29'b0, fifo_count}, 32'd2);
        reset = 1'b0;
        #1;
        chk("f_rst_count", {29'b0, fifo_count},   32'd0);
        chk("f_rst_valid", {31'b0, if_valid},     32'd0);
        chk("f_rst_ren",   {31'b0, inst_mem_ren}, 32'd0);
        chk("f_rst_inst",  if_instruction,        c_NOP);
        repeat (2) tick();
        stall = 1'b0;
        reset = 1'b1;
        #1;
        chk("f_rel_ren",  {31'b0, inst_mem_ren}, 32'd1);
        chk("f_rel_addr", inst_mem_address,      32'h0);

        // Asynchronous reset while a slow request is outstanding
        do_reset(3);
        tick();
        reset = 1'b0;
        #1;
        chk("o_rst_ren",  {31'b0, inst_mem_ren}, 32'd0);
        chk("o_rst_addr", inst_mem_address,      32'h0);
        repeat (2) tick();
        reset = 1'b1;
        #1;
        chk("o_rel_ren",  {31'b0, inst_mem_ren}, 32'd1);
        chk("o_rel_addr", inst_mem_address,      32'h0);
        wait_valid(10, "o_wait_valid");
        chk("o_first_pc", if_pc, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
